// File: rtl/fir_pkg.sv
// Shared register map, bit positions and statistics constants for fir_stream_monitor.
package fir_pkg;

    localparam int unsigned REG_W = 32;
    localparam int unsigned SUM_W = 48;

    localparam int unsigned ADDR_CTRL   = 'h00;
    localparam int unsigned ADDR_COUNT  = 'h04;
    localparam int unsigned ADDR_MIN    = 'h08;
    localparam int unsigned ADDR_MAX    = 'h0C;
    localparam int unsigned ADDR_SUM_LO = 'h10;
    localparam int unsigned ADDR_SUM_HI = 'h14;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_DONE_BIT   = 1;
    localparam int CTRL_CLEAR_BIT  = 2;
    localparam int CTRL_EMPTY_BIT  = 4;
    localparam int CTRL_FULL_BIT   = 5;

    // min starts at the largest signed value and max at the smallest, so the
    // first counted sample always replaces both.
    localparam logic [REG_W-1:0] STAT_MIN_RESET = 32'h7FFF_FFFF;
    localparam logic [REG_W-1:0] STAT_MAX_RESET = 32'h8000_0000;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    function automatic logic [REG_W-1:0] ctrl_word(input logic enable, input logic done,
                                                   input logic empty, input logic full);
        logic [REG_W-1:0] w;
        w = '0;
        w[CTRL_ENABLE_BIT] = enable;
        w[CTRL_DONE_BIT]   = done;
        w[CTRL_EMPTY_BIT]  = empty;
        w[CTRL_FULL_BIT]   = full;
        return w;
    endfunction

endpackage

// File: rtl/fir_stream_monitor_if.sv
// Stream-in, stream-out and AXI-Lite bundle of fir_stream_monitor.
// Every channel transfers on a rising edge where its valid and ready are both high.
interface fir_stream_monitor_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;

    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;

    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;

    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport slave (
        input  ss_tvalid, ss_tdata, ss_tlast,
        output ss_tready,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  sm_tready,
        input  awvalid, awaddr,
        output awready,
        input  wvalid, wdata,
        output wready,
        input  arvalid, araddr,
        output arready,
        output rvalid, rdata,
        input  rready
    );

    modport master (
        output ss_tvalid, ss_tdata, ss_tlast,
        input  ss_tready,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output sm_tready,
        output awvalid, awaddr,
        input  awready,
        output wvalid, wdata,
        input  wready,
        output arvalid, araddr,
        input  arready,
        input  rvalid, rdata,
        output rready
    );

endinterface

// File: rtl/axis_fifo.sv
// Small stream FIFO carrying data plus tlast; pointers have one extra wrap bit
// so full and empty are told apart without an occupancy counter.
module axis_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [pDATA_WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [pDATA_WIDTH-1:0] out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(pDEPTH);

    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic [pDATA_WIDTH:0] mem [pDEPTH];
    logic [pDATA_WIDTH:0] head;
    logic                 push;
    logic                 pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    assign in_ready  = !full;
    assign out_valid = !empty;

    // Head is masked while empty so the output bus reads zero out of reset.
    assign head     = mem[rd_ptr[PTR_W-1:0]];
    assign out_data = empty ? '0 : head[pDATA_WIDTH-1:0];
    assign out_last = empty ? 1'b0 : head[pDATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= {in_last, in_data};
    end

endmodule

// File: rtl/fir_stream_monitor.sv
// Pass-through buffer for the FIR output stream that keeps running count,
// min, max and sum of accepted samples, readable over AXI-Lite.
module fir_stream_monitor
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 4
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst_n,
    fir_stream_monitor_if.slave  bus
);

    logic                   fifo_in_ready;
    logic                   fifo_out_valid;
    logic [pDATA_WIDTH-1:0] fifo_out_data;
    logic                   fifo_out_last;
    logic                   fifo_full;
    logic                   fifo_empty;

    axis_fifo #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pDEPTH      (pDEPTH)
    ) u_fifo (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .in_valid  (bus.ss_tvalid),
        .in_data   (bus.ss_tdata),
        .in_last   (bus.ss_tlast),
        .in_ready  (fifo_in_ready),
        .out_valid (fifo_out_valid),
        .out_data  (fifo_out_data),
        .out_last  (fifo_out_last),
        .out_ready (bus.sm_tready),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.ss_tready = fifo_in_ready;
    assign bus.sm_tvalid = fifo_out_valid;
    assign bus.sm_tdata  = fifo_out_data;
    assign bus.sm_tlast  = fifo_out_last;

    logic in_fire;
    assign in_fire = bus.ss_tvalid && fifo_in_ready;

    // Write channel: address and data are taken together, one pulse per write.
    logic wr_rdy;
    logic wr_fire;
    logic ctrl_wr;
    logic clear_wr;
    logic wdata_unused;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_rdy <= 1'b0;
        end else if (wr_rdy) begin
            wr_rdy <= 1'b0;
        end else if (bus.awvalid && bus.wvalid) begin
            wr_rdy <= 1'b1;
        end
    end

    assign bus.awready = wr_rdy;
    assign bus.wready  = wr_rdy;
    assign wr_fire     = wr_rdy && bus.awvalid && bus.wvalid;
    assign ctrl_wr     = wr_fire && (bus.awaddr == pADDR_WIDTH'(ADDR_CTRL));
    assign clear_wr    = ctrl_wr && bus.wdata[CTRL_CLEAR_BIT];
    assign wdata_unused = &{1'b0, bus.wdata[pDATA_WIDTH-1:CTRL_CLEAR_BIT+1],
                           bus.wdata[CTRL_DONE_BIT]};

    logic                   enable;
    logic                   done;
    logic [pDATA_WIDTH-1:0] stat_count;
    logic [pDATA_WIDTH-1:0] stat_min;
    logic [pDATA_WIDTH-1:0] stat_max;
    logic [SUM_W-1:0]       stat_sum;

    // Clear outranks a sample accepted on the same edge; that sample is not counted.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            enable     <= 1'b0;
            done       <= 1'b0;
            stat_count <= '0;
            stat_sum   <= '0;
            stat_min   <= pDATA_WIDTH'(STAT_MIN_RESET);
            stat_max   <= pDATA_WIDTH'(STAT_MAX_RESET);
        end else begin
            if (clear_wr) begin
                done       <= 1'b0;
                stat_count <= '0;
                stat_sum   <= '0;
                stat_min   <= pDATA_WIDTH'(STAT_MIN_RESET);
                stat_max   <= pDATA_WIDTH'(STAT_MAX_RESET);
            end else if (in_fire) begin
                if (bus.ss_tlast) done <= 1'b1;
                if (enable) begin
                    stat_count <= stat_count + pDATA_WIDTH'(1);
                    stat_sum   <= stat_sum + SUM_W'($signed(bus.ss_tdata));
                    if ($signed(bus.ss_tdata) < $signed(stat_min)) stat_min <= bus.ss_tdata;
                    if ($signed(bus.ss_tdata) > $signed(stat_max)) stat_max <= bus.ss_tdata;
                end
            end
            if (ctrl_wr) enable <= bus.wdata[CTRL_ENABLE_BIT];
        end
    end

    logic [pDATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        case (bus.araddr)
            pADDR_WIDTH'(ADDR_CTRL):   rd_word = pDATA_WIDTH'(ctrl_word(enable, done,
                                                                      fifo_empty, fifo_full));
            pADDR_WIDTH'(ADDR_COUNT):  rd_word = stat_count;
            pADDR_WIDTH'(ADDR_MIN):    rd_word = stat_min;
            pADDR_WIDTH'(ADDR_MAX):    rd_word = stat_max;
            pADDR_WIDTH'(ADDR_SUM_LO): rd_word = stat_sum[pDATA_WIDTH-1:0];
            pADDR_WIDTH'(ADDR_SUM_HI): rd_word = pDATA_WIDTH'($signed(stat_sum[SUM_W-1:REG_W]));
            default:                   rd_word = '0;
        endcase
    end

    // Read FSM: address accepted in ADDR, data snapshotted into rdata and held in DATA.
    rd_state_e              rd_state;
    logic                   ar_rdy;
    logic                   r_vld;
    logic [pDATA_WIDTH-1:0] r_data;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rd_state <= RD_IDLE;
            ar_rdy   <= 1'b0;
            r_vld    <= 1'b0;
            r_data   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (bus.arvalid) begin
                        ar_rdy   <= 1'b1;
                        rd_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    ar_rdy   <= 1'b0;
                    r_vld    <= 1'b1;
                    r_data   <= rd_word;
                    rd_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (bus.rready) begin
                        r_vld    <= 1'b0;
                        rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    ar_rdy   <= 1'b0;
                    r_vld    <= 1'b0;
                    rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    assign bus.arready = ar_rdy;
    assign bus.rvalid  = r_vld;
    assign bus.rdata   = r_data;

endmodule

// File: tb/tb_fir_stream_monitor.sv
// Bench for fir_stream_monitor: register tables, hand-written corner sequences
// and a randomized stream checked against a queue-based reference model.
module tb_fir_stream_monitor;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic axis_clk = 1'b0;
  logic axis_rst_n;

  always #5 axis_clk = ~axis_clk;

  fir_stream_monitor_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_stream_monitor #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DW:0] exp_q[$];      // {tlast, tdata} accepted but not yet delivered
  int          counted_q[$];  // samples counted since the last clear
  bit          m_en;
  bit          m_done;
  int          n_pops = 0;

  always @(negedge axis_clk) begin
    if (!axis_rst_n) begin
      exp_q.delete();
      counted_q.delete();
      m_en   = 1'b0;
      m_done = 1'b0;
    end else begin
      bit in_fire;
      bit out_fire;
      bit wr_fire;
      bit ctrl_wr;
      bit clr;
      check("ss_tready_vs_occupancy", bus.ss_tready, exp_q.size() < DEPTH);
      check("sm_tvalid_vs_occupancy", bus.sm_tvalid, exp_q.size() != 0);
      if (bus.sm_tvalid && exp_q.size() != 0)
        check("sm_head", {bus.sm_tlast, bus.sm_tdata}, exp_q[0]);
      in_fire  = bus.ss_tvalid && bus.ss_tready;
      out_fire = bus.sm_tvalid && bus.sm_tready;
      wr_fire  = bus.awready && bus.awvalid && bus.wvalid;
      ctrl_wr  = wr_fire && (bus.awaddr == 12'h000);
      clr      = ctrl_wr && bus.wdata[2];
      if (out_fire && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (in_fire) exp_q.push_back({bus.ss_tlast, bus.ss_tdata});
      if (clr) begin
        counted_q.delete();
        m_done = 1'b0;
      end else if (in_fire) begin
        if (bus.ss_tlast) m_done = 1'b1;
        if (m_en) counted_q.push_back(int'(bus.ss_tdata));
      end
      if (ctrl_wr) m_en = bus.wdata[0];
    end
  end

  function automatic void model_stats(output logic [31:0] cnt, output logic [31:0] mn,
                                      output logic [31:0] mx, output logic [31:0] slo,
                                      output logic [31:0] shi);
    longint s;
    int lo;
    int hi;
    s  = 0;
    lo = 32'sh7FFF_FFFF;
    hi = -32'sh7FFF_FFFF - 1;
    foreach (counted_q[i]) begin
      s += longint'(counted_q[i]);
      if (counted_q[i] < lo) lo = counted_q[i];
      if (counted_q[i] > hi) hi = counted_q[i];
    end
    cnt = counted_q.size();
    mn  = lo;
    mx  = hi;
    slo = s[31:0];
    shi = {{16{s[47]}}, s[47:32]};
  endfunction

  // ---------------- drivers ----------------
  int sink_mode = 0;  // 0 always ready, 1 never ready, 2 random

  initial begin
    bus.sm_tready = 1'b0;
    forever begin
      @(posedge axis_clk);
      #1;
      case (sink_mode)
        0:       bus.sm_tready = 1'b1;
        1:       bus.sm_tready = 1'b0;
        default: bus.sm_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = d;
    bus.ss_tlast  = l;
    while (!bus.ss_tready && guard < 500) begin
      tick();
      guard++;
    end
    if (!bus.ss_tready) begin
      fail("send_accept");
      bus.ss_tvalid = 1'b0;
      return;
    end
    tick();
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d,
                            input bit inj = 1'b0, input logic [31:0] sd = '0);
    int guard;
    guard = 0;
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    while (!bus.awready && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.awready) begin
      fail("awready");
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      return;
    end
    check("wready_with_awready", bus.wready, 1'b1);
    if (inj) begin
      check("sample_ready_on_write_edge", bus.ss_tready, 1'b1);
      bus.ss_tvalid = 1'b1;
      bus.ss_tdata  = sd;
      bus.ss_tlast  = 1'b0;
    end
    tick();
    bus.awvalid   = 1'b0;
    bus.wvalid    = 1'b0;
    bus.ss_tvalid = 1'b0;
    check("awready_single_pulse", bus.awready, 1'b0);
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
    int guard;
    int stall;
    guard = 0;
    d = '0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    tick();
    while (!bus.arready && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.arready) begin
      fail("arready");
      bus.arvalid = 1'b0;
      return;
    end
    tick();
    bus.arvalid = 1'b0;
    check("rvalid_after_arready", bus.rvalid, 1'b1);
    check("arready_single_pulse", bus.arready, 1'b0);
    d = bus.rdata;
    stall = $urandom_range(0, 2);
    repeat (stall) begin
      tick();
      check("rvalid_hold", bus.rvalid, 1'b1);
      check("rdata_hold", bus.rdata, d);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("rvalid_drop", bus.rvalid, 1'b0);
  endtask

  task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axil_read(a, v);
    check(name, v, exp);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.sm_tvalid) && guard < 300) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0 || bus.sm_tvalid) fail("drain");
    tick();
  endtask

  task automatic check_model_regs();
    logic [31:0] cnt, mn, mx, slo, shi;
    model_stats(cnt, mn, mx, slo, shi);
    read_check("model_count", 12'h004, cnt);
    read_check("model_min", 12'h008, mn);
    read_check("model_max", 12'h00C, mx);
    read_check("model_sum_lo", 12'h010, slo);
    read_check("model_sum_hi", 12'h014, shi);
    read_check("model_ctrl", 12'h000, {26'd0, 1'b0, exp_q.size() == 0, 2'b00, m_done, m_en});
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t reset_tbl[8];
  reg_vec_t basic_tbl[6];

  bit stream_done;

  initial begin
    int pops0;
    logic [31:0] v;

    reset_tbl[0] = '{"rst_ctrl",     12'h000, 32'h0000_0010};
    reset_tbl[1] = '{"rst_count",    12'h004, 32'h0000_0000};
    reset_tbl[2] = '{"rst_min",      12'h008, 32'h7FFF_FFFF};
    reset_tbl[3] = '{"rst_max",      12'h00C, 32'h8000_0000};
    reset_tbl[4] = '{"rst_sum_lo",   12'h010, 32'h0000_0000};
    reset_tbl[5] = '{"rst_sum_hi",   12'h014, 32'h0000_0000};
    reset_tbl[6] = '{"unmapped_18",  12'h018, 32'h0000_0000};
    reset_tbl[7] = '{"unmapped_100", 12'h100, 32'h0000_0000};

    basic_tbl[0] = '{"basic_count",  12'h004, 32'd3};
    basic_tbl[1] = '{"basic_min",    12'h008, 32'hFFFF_FFFD};
    basic_tbl[2] = '{"basic_max",    12'h00C, 32'd10};
    basic_tbl[3] = '{"basic_sum_lo", 12'h010, 32'd12};
    basic_tbl[4] = '{"basic_sum_hi", 12'h014, 32'd0};
    basic_tbl[5] = '{"basic_ctrl",   12'h000, 32'h0000_0013};

    axis_rst_n    = 1'b0;
    bus.ss_tvalid = 1'b0;
    bus.ss_tdata  = '0;
    bus.ss_tlast  = 1'b0;
    bus.awvalid   = 1'b0;
    bus.awaddr    = '0;
    bus.wvalid    = 1'b0;
    bus.wdata     = '0;
    bus.arvalid   = 1'b0;
    bus.araddr    = '0;
    bus.rready    = 1'b0;
    stream_done   = 1'b0;

    // Reset values on the pins.
    repeat (3) tick();
    check("rst_ss_tready", bus.ss_tready, 1'b1);
    check("rst_sm_tvalid", bus.sm_tvalid, 1'b0);
    check("rst_sm_tdata", bus.sm_tdata, 32'd0);
    check("rst_sm_tlast", bus.sm_tlast, 1'b0);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 32'd0);
    axis_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) read_check(reset_tbl[i].name, reset_tbl[i].addr, reset_tbl[i].exp);

    // Basic statistics: 5, -3, 10 with tlast on the last one.
    axil_write(12'h000, 32'h1);
    sink_mode = 0;
    send(32'd5, 1'b0);
    send(-32'sd3, 1'b0);
    send(32'd10, 1'b1);
    wait_drain();
    for (int i = 0; i < 6; i++) read_check(basic_tbl[i].name, basic_tbl[i].addr, basic_tbl[i].exp);

    // Backpressure: six samples into a stalled sink.
    axil_write(12'h000, 32'h5);
    sink_mode = 1;
    tick();
    tick();
    pops0 = n_pops;
    for (int i = 0; i < 4; i++) send(32'd100 + i, 1'b0);
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = 32'd104;
    bus.ss_tlast  = 1'b0;
    tick();
    tick();
    check("full_ss_tready_low", bus.ss_tready, 1'b0);
    read_check("full_ctrl", 12'h000, 32'h0000_0021);
    sink_mode = 0;
    send(32'd104, 1'b0);
    send(32'd105, 1'b1);
    wait_drain();
    check("backpressure_pops", n_pops - pops0, 6);
    read_check("backpressure_count", 12'h004, 32'd6);
    read_check("backpressure_ctrl", 12'h000, 32'h0000_0013);

    // Sum wrap around the 32-bit boundary in both directions.
    axil_write(12'h000, 32'h5);
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    read_check("sum_pos_lo", 12'h010, 32'hFFFF_FFFE);
    read_check("sum_pos_hi", 12'h014, 32'h0000_0000);
    send(32'h8000_0000, 1'b0);
    send(32'h8000_0000, 1'b0);
    read_check("sum_neg_lo", 12'h010, 32'hFFFF_FFFE);
    read_check("sum_neg_hi", 12'h014, 32'hFFFF_FFFF);
    read_check("sum_extreme_min", 12'h008, 32'h8000_0000);
    read_check("sum_extreme_max", 12'h00C, 32'h7FFF_FFFF);

    // Clear on the same edge as an accepted sample.
    sink_mode = 1;
    tick();
    tick();
    axil_write(12'h000, 32'h5, 1'b1, 32'h0000_1234);
    read_check("clr_edge_count", 12'h004, 32'd0);
    read_check("clr_edge_ctrl", 12'h000, 32'h0000_0001);
    check("clr_edge_sm_tvalid", bus.sm_tvalid, 1'b1);
    check("clr_edge_sm_tdata", bus.sm_tdata, 32'h0000_1234);
    sink_mode = 0;
    wait_drain();

    // Reset in the middle of a transfer discards buffered samples.
    sink_mode = 1;
    tick();
    tick();
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    axis_rst_n = 1'b0;
    #2;
    check("midrst_ss_tready", bus.ss_tready, 1'b1);
    check("midrst_sm_tvalid", bus.sm_tvalid, 1'b0);
    check("midrst_sm_tdata", bus.sm_tdata, 32'd0);
    tick();
    tick();
    axis_rst_n = 1'b1;
    sink_mode = 0;
    tick();
    read_check("midrst_ctrl", 12'h000, 32'h0000_0010);
    read_check("midrst_min", 12'h008, 32'h7FFF_FFFF);

    // Disabled stats still record done.
    send(32'd7, 1'b1);
    wait_drain();
    read_check("disabled_count", 12'h004, 32'd0);
    read_check("disabled_ctrl", 12'h000, 32'h0000_0012);

    // Long random stream with a random sink and concurrent count reads.
    axil_write(12'h000, 32'h5);
    sink_mode   = 2;
    pops0       = n_pops;
    stream_done = 1'b0;
    fork
      begin
        logic [31:0] d;
        for (int i = 0; i < 600; i++) begin
          d = $urandom();
          if ($urandom_range(0, 3) == 0) tick();
          send(d, i == 599);
        end
        stream_done = 1'b1;
      end
      begin
        logic [31:0] prev;
        logic [31:0] cv;
        prev = '0;
        while (!stream_done) begin
          axil_read(12'h004, cv);
          check("count_progress", (cv >= prev) && (cv <= 32'd600), 1'b1);
          prev = cv;
          repeat ($urandom_range(0, 5)) tick();
        end
      end
    join
    sink_mode = 0;
    wait_drain();
    check("stream_pops", n_pops - pops0, 600);
    read_check("stream_count", 12'h004, 32'd600);
    check_model_regs();
    axil_read(12'h000, v);
    check("stream_done_bit", v[1], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
